// File: rtl/sram_dp_be_clr.sv
// Simple dual-port SRAM: byte-enabled write port A, read port B, one clock.
// A clear engine zeroes one word per cycle after reset or on clr_req.
module sram_dp_be_clr #(
    parameter int DW      = 128,
    parameter int DEPTH   = 4096,
    parameter int AW      = 12,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = 0
) (
    input  logic            clka,
    input  logic            rstn,
    input  logic            clr_req,
    output logic            clr_busy,
    input  logic            ena,
    input  logic            wea,
    input  logic [DW/8-1:0] bea,
    input  logic [AW-1:0]   addra,
    input  logic [DW-1:0]   dina,
    output logic            wr_drop,
    input  logic            enb,
    input  logic [AW-1:0]   addrb,
    output logic [DW-1:0]   doutb,
    output logic            doutb_vld
);

    localparam int NB = DW / 8;
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state;
    logic [AW-1:0]   clr_addr;
    logic [DW-1:0]   ram [DEPTH];

    logic            a_oob, b_oob;
    logic            wr_req, wr_ok, collide, rd_zero;
    logic [DW-1:0]   rd_word, merged, rd_next;
    logic            s1_vld;
    logic [DW-1:0]   s1_data;

    assign a_oob    = {1'b0, addra} >= DEPTH_X;
    assign b_oob    = {1'b0, addrb} >= DEPTH_X;
    assign wr_req   = ena & wea & (|bea);
    assign wr_ok    = wr_req & (state == IDLE) & ~a_oob;
    assign collide  = wr_ok & (addra == addrb);
    assign rd_zero  = (state == CLEAR) | b_oob;
    assign clr_busy = (state == CLEAR);

    always_comb begin
        rd_word = b_oob ? '0 : ram[addrb];
        merged  = rd_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (bea[i]) merged[8*i +: 8] = dina[8*i +: 8];
        end
        if (rd_zero)
            rd_next = '0;
        else if (WR_MODE == 1 && collide)
            rd_next = merged;
        else
            rd_next = rd_word;
    end

    always_ff @(posedge clka) begin
        if (!rstn) begin
            state    <= CLEAR;
            clr_addr <= '0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= wr_req & ((state == CLEAR) | a_oob);
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST) begin
                        state    <= IDLE;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Array has no reset; the clear engine owns its contents while busy.
    always_ff @(posedge clka) begin
        if (rstn && state == CLEAR) begin
            ram[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bea[i]) ram[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (!rstn) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= enb;
            if (enb) s1_data <= rd_next;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic            s2_vld;
            logic [DW-1:0]   s2_data;
            always_ff @(posedge clka) begin
                if (!rstn) begin
                    s2_vld  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_data <= s1_data;
                end
            end
            assign doutb     = s2_data;
            assign doutb_vld = s2_vld;
        end else begin : g_lat1
            assign doutb     = s1_data;
            assign doutb_vld = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_sram_dp_be_clr.sv
// Directed bench: two instances sharing stimulus, DEPTH=3000,
// one read-first with RD_LAT=1, one write-first with RD_LAT=2.
module tb_sram_dp_be_clr;

    localparam int DW    = 128;
    localparam int DEPTH = 3000;
    localparam int AW    = 12;
    localparam int NB    = DW / 8;

    logic            clka = 1'b0;
    logic            rstn, clr_req, ena, wea, enb;
    logic [NB-1:0]   bea;
    logic [AW-1:0]   addra, addrb;
    logic [DW-1:0]   dina;
    logic            busy0, busy1, drop0, drop1, vld0, vld1;
    logic [DW-1:0]   dout0, dout1;

    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    sram_dp_be_clr #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .RD_LAT(1), .WR_MODE(0)) u0 (
        .clka(clka), .rstn(rstn), .clr_req(clr_req), .clr_busy(busy0),
        .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina), .wr_drop(drop0),
        .enb(enb), .addrb(addrb), .doutb(dout0), .doutb_vld(vld0)
    );

    sram_dp_be_clr #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .RD_LAT(2), .WR_MODE(1)) u1 (
        .clka(clka), .rstn(rstn), .clr_req(clr_req), .clr_busy(busy1),
        .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina), .wr_drop(drop1),
        .enb(enb), .addrb(addrb), .doutb(dout1), .doutb_vld(vld1)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clear(input string tag, input int exp);
        int n = 0;
        while (busy0 && n < DEPTH + 50) begin
            n++;
            @(negedge clka);
        end
        check({tag, "_len"}, n, exp);
        check({tag, "_busy1"}, busy1, 0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] be, input logic edrop, input string tag);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d; bea = be;
        @(negedge clka);
        ena = 1'b0; wea = 1'b0;
        check({tag, "_drop0"}, drop0, edrop);
        check({tag, "_drop1"}, drop1, edrop);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e0,
                      input logic [DW-1:0] e1, input string tag);
        enb = 1'b1; addrb = a;
        @(negedge clka);
        enb = 1'b0;
        check({tag, "_v0"}, vld0, 1);
        check({tag, "_d0"}, dout0, e0);
        check({tag, "_v1early"}, vld1, 0);
        @(negedge clka);
        check({tag, "_v1"}, vld1, 1);
        check({tag, "_d1"}, dout1, e1);
        check({tag, "_v0off"}, vld0, 0);
        check({tag, "_d0hold"}, dout0, e0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] pa, pb, pc, pd, acc0, acc1;
        int nv0, nv1;

        rstn = 1'b0; clr_req = 1'b0; ena = 1'b0; wea = 1'b0; enb = 1'b0;
        bea = '0; addra = '0; addrb = '0; dina = '0;
        repeat (3) @(negedge clka);
        check("rst_dout0", dout0, 0);
        check("rst_dout1", dout1, 0);
        check("rst_vld0", vld0, 0);
        check("rst_vld1", vld1, 0);
        check("rst_drop0", drop0, 0);
        check("rst_busy0", busy0, 1);
        check("rst_busy1", busy1, 1);

        rstn = 1'b1;
        wait_clear("rst_clr", DEPTH);

        // sweep every address back-to-back; u1 trails u0 by one cycle
        acc0 = '0; acc1 = '0; nv0 = 0; nv1 = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            enb   = (i < DEPTH);
            addrb = AW'(i);
            @(negedge clka);
            if (i < DEPTH) begin acc0 |= dout0; nv0 += int'(vld0); end
            if (i >= 1 && i <= DEPTH) begin acc1 |= dout1; nv1 += int'(vld1); end
        end
        enb = 1'b0;
        check("sweep_or0", acc0, 0);
        check("sweep_or1", acc1, 0);
        check("sweep_nv0", nv0, DEPTH);
        check("sweep_nv1", nv1, DEPTH);

        pa = {16{8'hAA}};
        pb = {16{8'h55}};
        pc = {{15{8'hAA}}, 8'h55};
        wr(12'd5, pa, '1, 1'b0, "wr5a");
        wr(12'd5, pb, 16'h0001, 1'b0, "wr5b");
        rd(12'd5, pc, pc, "rd5");

        wr(12'd5, '1, '0, 1'b0, "wr5_be0");
        rd(12'd5, pc, pc, "rd5_be0");

        pd = 128'h1234;
        ena = 1'b1; wea = 1'b1; addra = 12'd9; dina = pd; bea = '1;
        enb = 1'b1; addrb = 12'd9;
        @(negedge clka);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        check("col_drop0", drop0, 0);
        check("col_v0", vld0, 1);
        check("col_d0", dout0, 0);
        @(negedge clka);
        check("col_v1", vld1, 1);
        check("col_d1", dout1, pd);
        rd(12'd9, pd, pd, "rd9_after");

        enb = 1'b1; addrb = 12'd5;
        @(negedge clka);
        addrb = 12'd9;
        check("b2b_d0a", dout0, pc);
        @(negedge clka);
        enb = 1'b0;
        check("b2b_d0b", dout0, pd);
        check("b2b_v0b", vld0, 1);
        check("b2b_d1a", dout1, pc);
        @(negedge clka);
        check("b2b_d1b", dout1, pd);
        check("b2b_v1b", vld1, 1);

        pa = {8{16'hC3E1}};
        wr(12'd2999, pa, '1, 1'b0, "wr2999");
        ena = 1'b1; wea = 1'b1; addra = 12'd3500; dina = '1; bea = '1;
        enb = 1'b1; addrb = 12'd3500;
        @(negedge clka);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        check("oob_drop0", drop0, 1);
        check("oob_drop1", drop1, 1);
        check("oob_v0", vld0, 1);
        check("oob_d0", dout0, 0);
        @(negedge clka);
        check("oob_v1", vld1, 1);
        check("oob_d1", dout1, 0);
        check("oob_drop_pulse", drop0, 0);
        rd(12'd2999, pa, pa, "rd2999");

        wr(12'd1, pb, '1, 1'b0, "wr1");
        wr(12'd2, pb, '1, 1'b0, "wr2");
        wr(12'd3, pb, '1, 1'b0, "wr3");
        clr_req = 1'b1;
        @(negedge clka);
        clr_req = 1'b0;
        check("clr_busy0", busy0, 1);
        clr_req = 1'b1;
        wr(12'd7, pb, '1, 1'b1, "wr_in_clr");
        clr_req = 1'b0;
        rd(12'd1, 0, 0, "rd_in_clr");
        wait_clear("req_clr", DEPTH - 3);
        rd(12'd1, 0, 0, "rd1_clr");
        rd(12'd2, 0, 0, "rd2_clr");
        rd(12'd3, 0, 0, "rd3_clr");
        rd(12'd5, 0, 0, "rd5_clr");
        rd(12'd7, 0, 0, "rd7_clr");
        rd(12'd2999, 0, 0, "rd2999_clr");

        wr(12'd4, pb, '1, 1'b0, "wr4");
        clr_req = 1'b1;
        @(negedge clka);
        clr_req = 1'b0;
        repeat (99) @(negedge clka);
        enb = 1'b1; addrb = 12'd4;
        @(negedge clka);
        enb = 1'b0;
        rstn = 1'b0;
        @(negedge clka);
        check("sq_v1", vld1, 0);
        check("sq_v0", vld0, 0);
        check("sq_busy", busy0, 1);
        rstn = 1'b1;
        wait_clear("rst_mid", DEPTH);
        rd(12'd4, 0, 0, "rd4_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
